// File: rtl/rgb2hsv_ctrl.sv
// rgb2hsv_ctrl: sync delay, frame-aligned mode switching, pixel coordinates and output blanking for the colour stage
module rgb2hsv_ctrl #(
    parameter int LAT = 3,
    parameter int XW  = 11,
    parameter int YW  = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          de_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic [1:0]    mode_req,
    input  logic          mode_wr,
    output logic [1:0]    mode_act,
    output logic          pend,
    output logic          de_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_start,
    output logic          blank
);
    localparam int DW = $clog2(LAT + 1);
    typedef enum logic [1:0] {SYNC_WAIT, RUN, FLUSH} state_t;
    state_t          state_q;
    logic [LAT-1:0]  de_q, hs_q, vs_q;
    logic            vs_in_prev_q, de_out_prev_q, vs_out_prev_q;
    logic [1:0]      mode_act_q, mode_pend_q;
    logic            pend_q, blank_q;
    logic [DW-1:0]   drain_q;
    logic [XW-1:0]   pix_x_q, pix_x_d;
    logic [YW-1:0]   pix_y_q, pix_y_d;
    logic            vs_in_rise, vs_out_rise, de_out_fall;
    assign de_out      = de_q[LAT-1];
    assign hsync_out   = hs_q[LAT-1];
    assign vsync_out   = vs_q[LAT-1];
    assign vs_in_rise  = vsync_in & ~vs_in_prev_q;
    assign vs_out_rise = vsync_out & ~vs_out_prev_q;
    assign de_out_fall = ~de_out & de_out_prev_q;
    // Combinational so the pulse can never show up in a ce=0 cycle
    assign frame_start = ce & vs_out_rise;
    assign mode_act    = mode_act_q;
    assign pend        = pend_q;
    assign blank       = blank_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    always_comb begin
        pix_x_d = (vs_out_rise || de_out_fall) ? '0 :
                  (de_out && !(&pix_x_q)) ? pix_x_q + XW'(1) : pix_x_q;
        pix_y_d = vs_out_rise ? '0 :
                  (de_out_fall && !(&pix_y_q)) ? pix_y_q + YW'(1) : pix_y_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_q          <= '0;
            hs_q          <= '0;
            vs_q          <= '0;
            vs_in_prev_q  <= 1'b0;
            de_out_prev_q <= 1'b0;
            vs_out_prev_q <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            mode_act_q    <= 2'd0;
            mode_pend_q   <= 2'd0;
            pend_q        <= 1'b0;
            blank_q       <= 1'b1;
            drain_q       <= '0;
            state_q       <= SYNC_WAIT;
        end else if (ce) begin
            de_q          <= (de_q << 1) | LAT'(de_in);
            hs_q          <= (hs_q << 1) | LAT'(hsync_in);
            vs_q          <= (vs_q << 1) | LAT'(vsync_in);
            vs_in_prev_q  <= vsync_in;
            de_out_prev_q <= de_out;
            vs_out_prev_q <= vsync_out;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            if (vs_in_rise && pend_q) begin
                mode_act_q <= mode_pend_q;
                pend_q     <= 1'b0;
                drain_q    <= DW'(LAT);
                blank_q    <= 1'b1;
                state_q    <= FLUSH;
            end else if (state_q == SYNC_WAIT && vs_in_rise) begin
                blank_q <= 1'b0;
                state_q <= RUN;
            end else if (state_q == FLUSH) begin
                drain_q <= drain_q - DW'(1);
                if (drain_q <= DW'(1)) begin
                    blank_q <= 1'b0;
                    state_q <= RUN;
                end
            end
            // A write coinciding with a boundary is kept for the next frame
            if (mode_wr) begin
                mode_pend_q <= mode_req;
                pend_q      <= 1'b1;
            end
        end
    end
endmodule
